k_centroid_div_seq: RTL
=======================

Name: k_centroid_div_seq

Overview:
- Sequencer directly upstream of the k-means approximate fp16 divider. It turns per-cluster accumulator results (fp16 coordinate sum, integer member count) into centroid = sum / count.
- Per cluster entry it:
  - converts the count to fp16;
  - drives the divider's in1/in2/en;
  - waits for done and captures the quotient;
  - restores the sign.
- Degenerate cases (empty cluster, count 1, zero/special sum) bypass the divider. Results go downstream on a valid/ready stream.

Parameters:
- IDX_W, 4, width of cluster/coordinate index tag carried through.
- DIV_TIMEOUT, 8, max cycles in ISSUE waiting for div_done before abort (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input entry valid
- in_ready  out  1  block can accept entry (high only in IDLE)
- in_idx  in  IDX_W  tag of entry
- in_sum  in  16  fp16 coordinate sum
- in_cnt  in  16  unsigned member count
- in_old  in  16  previous fp16 centroid (used if cluster empty/timeout)
- div_in1  out  16  dividend to divider, sign forced 0
- div_in2  out  16  fp16 count to divider
- div_en  out  1  divider enable
- div_done  in  1  divider done (registered, one cycle after en)
- div_out  in  16  divider quotient (valid while done=1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_idx  out  IDX_W  tag of result
- out_centroid  out  16  fp16 new centroid
- out_empty  out  1  result is in_old because in_cnt==0
- out_timeout  out  1  result is in_old because divider timed out
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; all outputs 0 except in_ready=1; wait counter 0. Reset mid-operation drops div_en the next cycle, discards the entry and emits no result.
- FSM states: IDLE, CONV, ISSUE, OUT.
- IDLE: in_ready=1. On in_valid, register idx/sum/cnt/old.
  - cnt==0 -> OUT with centroid=old, empty=1.
  - cnt==1, or sum exp==0 (zero/subnormal), or sum exp==31 (Inf/NaN) -> OUT, bypassing the divider:
    - centroid=sum for cnt==1 or exp==31;
    - centroid=16'h0000 for exp==0.
  - else -> CONV.
- CONV (1 cycle):
  - div_in1={1'b0,sum[14:0]}.
  - div_in2=fp16(cnt): p=index of MSB of cnt; exp=15+p; mantissa=cnt bits below MSB left-aligned into 10 bits, truncated (exact for cnt≤2048). Sign 0.
  - Go to ISSUE with wait counter cleared.
- ISSUE: div_en=1, held every cycle. div_in1/div_in2 stay constant from CONV until capture.
  - On div_done=1: capture centroid={sum[15],div_out[14:0]} -> OUT.
  - Else counter++. When counter reaches DIV_TIMEOUT: centroid=old, timeout=1 -> OUT.
- OUT: div_en=0, out_valid=1. out_* held stable until out_ready=1, then -> IDLE. If out_ready is already high on entry, out_valid lasts exactly 1 cycle. in_ready=0 here, so accept and output never coincide.
- Latency from accept edge to out_valid: divider path 4 cycles (CONV, ISSUE, done cycle, OUT); bypass 1 cycle.
- Throughput: one entry per latency+1 cycles minimum. No pipelining; single entry in flight.
- busy=1 in CONV/ISSUE/OUT. out_empty/out_timeout are cleared on entry to OUT for normal results.

Test Plan:
- Reset: rst=1 for 2 cycles mid-ISSUE -> next cycle div_en=0, busy=0, in_ready=1, out_valid=0, no result emitted.
- Normal divide: sum=0xCA00 (-12.0), cnt=3, idx=5; stub divider returns done one cycle after en with div_out=0x4400 -> div_in1=0x4A00, div_in2=0x4200, out_valid 4 cycles after accept, out_centroid=0xC400, out_idx=5, flags 0.
- Count conversion: cnt=2048 -> div_in2=0x6800; cnt=65535 -> div_in2=0x7BFF; cnt=5 -> div_in2=0x4500.
- Bypass: cnt=0, old=0x3C00 -> out_centroid=0x3C00, out_empty=1 one cycle after accept; cnt=1, sum=0x4900 -> 0x4900, div_en never asserted.
- Timeout: div_done tied 0, DIV_TIMEOUT=8 -> div_en high exactly 8 cycles, out_centroid=in_old, out_timeout=1.
- Backpressure: out_ready=0 for 5 cycles -> out_* stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle, then accepts the next entry.

Source files
------------

// File: rtl/k_centroid_div_seq_if.sv
// Handshake and divider bus of the k-means centroid divide sequencer.
// The master side is the sequencer; the slave side is its environment
// (the accumulator, the fp16 divider and the downstream consumer).
interface k_centroid_div_seq_if #(
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic [15:0]      in_sum;
    logic [15:0]      in_cnt;
    logic [15:0]      in_old;
    logic [15:0]      div_in1;
    logic [15:0]      div_in2;
    logic             div_en;
    logic             div_done;
    logic [15:0]      div_out;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [15:0]      out_centroid;
    logic             out_empty;
    logic             out_timeout;
    logic             busy;

    modport master (
        input  in_valid, in_idx, in_sum, in_cnt, in_old,
        input  div_done, div_out, out_ready,
        output in_ready, div_in1, div_in2, div_en,
        output out_valid, out_idx, out_centroid, out_empty, out_timeout, busy
    );

    modport slave (
        output in_valid, in_idx, in_sum, in_cnt, in_old,
        output div_done, div_out, out_ready,
        input  in_ready, div_in1, div_in2, div_en,
        input  out_valid, out_idx, out_centroid, out_empty, out_timeout, busy
    );
endinterface

// File: rtl/k_centroid_div_seq.sv
// Centroid divide sequencer: turns one (fp16 sum, integer count) entry into
// centroid = sum / count using the external approximate fp16 divider, with
// bypasses for empty clusters, single members and zero/special sums.
// One entry in flight at a time; all outputs are registered.
module k_centroid_div_seq #(
    parameter int IDX_W       = 4,
    parameter int DIV_TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    k_centroid_div_seq_if.master      bus
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(DIV_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CONV, ISSUE, OUT} state_t;

    state_t           state;
    logic [CW-1:0]    wait_cnt;
    logic [IDX_W-1:0] idx_p0;
    logic [15:0]      sum_p0;
    logic [15:0]      cnt_p0;
    logic [15:0]      old_p0;
    logic [4:0]       in_exp;

    // Unsigned count to fp16: exponent from the leading one, mantissa is the
    // bits below it left-aligned and truncated. Only called with cnt >= 2.
    function automatic logic [15:0] cnt_to_fp16(input logic [15:0] cnt);
        logic [3:0]  p;
        logic [15:0] sh;
        p = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (cnt[i]) p = 4'(i);
        end
        sh = cnt << (4'd15 - p);
        return {1'b0, 5'd15 + {1'b0, p}, sh[14:5]};
    endfunction

    assign in_exp = bus.in_sum[14:10];

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            bus.in_ready     <= 1'b1;
            bus.busy         <= 1'b0;
            bus.div_en       <= 1'b0;
            bus.div_in1      <= 16'h0000;
            bus.div_in2      <= 16'h0000;
            bus.out_valid    <= 1'b0;
            bus.out_idx      <= '0;
            bus.out_centroid <= 16'h0000;
            bus.out_empty    <= 1'b0;
            bus.out_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        idx_p0       <= bus.in_idx;
                        sum_p0       <= bus.in_sum;
                        cnt_p0       <= bus.in_cnt;
                        old_p0       <= bus.in_old;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        if (bus.in_cnt == 16'd0) begin
                            // Empty cluster keeps its previous centroid.
                            bus.out_idx      <= bus.in_idx;
                            bus.out_centroid <= bus.in_old;
                            bus.out_empty    <= 1'b1;
                            bus.out_timeout  <= 1'b0;
                            bus.out_valid    <= 1'b1;
                            state            <= OUT;
                        end else if (bus.in_cnt == 16'd1 || in_exp == 5'd31) begin
                            // sum/1 and Inf/NaN pass through unchanged.
                            bus.out_idx      <= bus.in_idx;
                            bus.out_centroid <= bus.in_sum;
                            bus.out_empty    <= 1'b0;
                            bus.out_timeout  <= 1'b0;
                            bus.out_valid    <= 1'b1;
                            state            <= OUT;
                        end else if (in_exp == 5'd0) begin
                            // Zero or subnormal sum flushes to +0.
                            bus.out_idx      <= bus.in_idx;
                            bus.out_centroid <= 16'h0000;
                            bus.out_empty    <= 1'b0;
                            bus.out_timeout  <= 1'b0;
                            bus.out_valid    <= 1'b1;
                            state            <= OUT;
                        end else begin
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    // Divider sees a magnitude; the sign is restored on capture.
                    bus.div_in1 <= {1'b0, sum_p0[14:0]};
                    bus.div_in2 <= cnt_to_fp16(cnt_p0);
                    bus.div_en  <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (bus.div_done) begin
                        bus.out_idx      <= idx_p0;
                        bus.out_centroid <= {sum_p0[15], bus.div_out[14:0]};
                        bus.out_empty    <= 1'b0;
                        bus.out_timeout  <= 1'b0;
                        bus.out_valid    <= 1'b1;
                        bus.div_en       <= 1'b0;
                        state            <= OUT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Divider never answered: fall back to the old centroid.
                        bus.out_idx      <= idx_p0;
                        bus.out_centroid <= old_p0;
                        bus.out_empty    <= 1'b0;
                        bus.out_timeout  <= 1'b1;
                        bus.out_valid    <= 1'b1;
                        bus.div_en       <= 1'b0;
                        state            <= OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
